// File: rtl/gsensor_spi_pkg.sv
// Shared constants, command layout and FSM state type
// for the accelerometer-style SPI register slave.
package gsensor_spi_pkg;

  localparam logic [5:0] ADDR_DEVID      = 6'h00;
  localparam logic [5:0] ADDR_RW_LO      = 6'h1D;
  localparam logic [5:0] ADDR_INT_ENABLE = 6'h2E;
  localparam logic [5:0] ADDR_INT_MAP    = 6'h2F;
  localparam logic [5:0] ADDR_RW_HI      = 6'h31;
  localparam logic [5:0] ADDR_DATAX0     = 6'h32;
  localparam logic [5:0] ADDR_DATAX1     = 6'h33;
  localparam logic [5:0] ADDR_DATAY0     = 6'h34;
  localparam logic [5:0] ADDR_DATAY1     = 6'h35;
  localparam logic [5:0] ADDR_DATAZ0     = 6'h36;
  localparam logic [5:0] ADDR_DATAZ1     = 6'h37;

  localparam int NUM_RW = 21;
  localparam int IDX_INT_ENABLE =
    int'(ADDR_INT_ENABLE) - int'(ADDR_RW_LO);
  localparam int IDX_INT_MAP =
    int'(ADDR_INT_MAP) - int'(ADDR_RW_LO);

  localparam int CMD_RNW      = 7;
  localparam int CMD_MB       = 6;
  localparam int CMD_ADDR_MSB = 5;
  localparam int CMD_ADDR_LSB = 0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CMD,
    ST_DATA
  } state_e;

  function automatic logic is_rw(
    input logic [5:0] a
  );
    return (a >= ADDR_RW_LO) && (a <= ADDR_RW_HI);
  endfunction

  function automatic logic is_data(
    input logic [5:0] a
  );
    return (a >= ADDR_DATAX0) && (a <= ADDR_DATAZ1);
  endfunction

endpackage

// File: rtl/gsensor_spi_sync.sv
// Synchroniser and edge detector for CSN, SCLK and SDI.
// Ports: clk/rst, raw csn/sclk/sdi in; synced csn/sdi,
// csn_fall/csn_rise, sclk_rise/sclk_fall strobes out.
module gsensor_spi_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic csn,
  input  logic sclk,
  input  logic sdi,
  output logic csn_s,
  output logic sdi_s,
  output logic csn_fall,
  output logic csn_rise,
  output logic sclk_rise,
  output logic sclk_fall
);

  logic [SYNC_STAGES-1:0] csn_sh_q, csn_sh_d;
  logic [SYNC_STAGES-1:0] sclk_sh_q, sclk_sh_d;
  logic [SYNC_STAGES-1:0] sdi_sh_q, sdi_sh_d;
  logic csn_prev_q, csn_prev_d;
  logic sclk_prev_q, sclk_prev_d;
  logic sclk_s;

  always_comb begin
    csn_sh_d  = {csn_sh_q[SYNC_STAGES-2:0], csn};
    sclk_sh_d = {sclk_sh_q[SYNC_STAGES-2:0], sclk};
    sdi_sh_d  = {sdi_sh_q[SYNC_STAGES-2:0], sdi};
    csn_prev_d  = csn_sh_q[SYNC_STAGES-1];
    sclk_prev_d = sclk_sh_q[SYNC_STAGES-1];
  end

  // CSN resets low ("busy"): a transaction can only start
  // after CSN has been observed high following reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      csn_sh_q    <= '0;
      sclk_sh_q   <= '1;
      sdi_sh_q    <= '0;
      csn_prev_q  <= 1'b0;
      sclk_prev_q <= 1'b1;
    end else begin
      csn_sh_q    <= csn_sh_d;
      sclk_sh_q   <= sclk_sh_d;
      sdi_sh_q    <= sdi_sh_d;
      csn_prev_q  <= csn_prev_d;
      sclk_prev_q <= sclk_prev_d;
    end
  end

  assign csn_s     = csn_sh_q[SYNC_STAGES-1];
  assign sclk_s    = sclk_sh_q[SYNC_STAGES-1];
  assign sdi_s     = sdi_sh_q[SYNC_STAGES-1];
  assign csn_fall  = csn_prev_q & ~csn_s;
  assign csn_rise  = ~csn_prev_q & csn_s;
  assign sclk_rise = ~sclk_prev_q & sclk_s;
  assign sclk_fall = sclk_prev_q & ~sclk_s;

endmodule

// File: rtl/gsensor_spi_slave.sv
// SPI mode-3 register slave: DEVID, 21 r/w regs, XYZ data.
// Ports: iCLK/iRST, SPI pins, iSAMPLE strobe, oINT2, oWR_*.
// Build option GSENSOR_SPI_BURST_EN: MB=1 auto-increments.
module gsensor_spi_slave #(
  parameter logic [7:0] DEVID       = 8'hE5,
  parameter int         SYNC_STAGES = 2
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iSPI_CSN,
  input  logic        iSPI_CLK,
  input  logic        iSPI_SDI,
  output logic        oSPI_SDO,
  output logic        oSPI_SDO_OE,
  input  logic [47:0] iSAMPLE,
  input  logic        iSAMPLE_VALID,
  output logic        oINT2,
  output logic        oWR_STB,
  output logic [5:0]  oWR_ADDR,
  output logic [7:0]  oWR_DATA
);
  import gsensor_spi_pkg::*;

  logic csn_s, sdi_s, csn_fall, csn_rise;
  logic sclk_rise, sclk_fall, sclk_re, sclk_fe;

  state_e state_q, state_d;
  logic [2:0] bit_q, bit_d;
  logic [6:0] rx_q, rx_d;
  logic [7:0] tx_q, tx_d;
  logic tx_dat_q, tx_dat_d;
  logic [5:0] addr_q, addr_d;
  logic rnw_q, rnw_d;
  logic hit_q, hit_d;
`ifdef GSENSOR_SPI_BURST_EN
  logic mb_q, mb_d;
`endif
  logic [NUM_RW-1:0][7:0] rw_q, rw_d;
  logic [5:0][7:0] dat_q, dat_d;
  logic [47:0] pend_q, pend_d;
  logic pend_vld_q, pend_vld_d;
  logic rdy_q, rdy_d;
  logic sdo_q, sdo_d;
  logic oe_q, oe_d;
  logic int2_q, int2_d;
  logic stb_q, stb_d;
  logic [5:0] wa_q, wa_d;
  logic [7:0] wd_q, wd_d;

  logic [7:0] byte_in;
  logic [5:0] cmd_addr;
  logic [5:0] nxt_addr;
  logic [4:0] wr_off;

  gsensor_spi_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk      (iCLK),
    .rst      (iRST),
    .csn      (iSPI_CSN),
    .sclk     (iSPI_CLK),
    .sdi      (iSPI_SDI),
    .csn_s    (csn_s),
    .sdi_s    (sdi_s),
    .csn_fall (csn_fall),
    .csn_rise (csn_rise),
    .sclk_rise(sclk_rise),
    .sclk_fall(sclk_fall)
  );

  assign sclk_re = sclk_rise & ~csn_s;
  assign sclk_fe = sclk_fall & ~csn_s;

  // Offsets use modular 5/3-bit arithmetic; the ranges
  // are contiguous and shorter than the modulus.
  function automatic logic [7:0] reg_rd(
    input logic [5:0] a
  );
    logic [4:0] ro;
    logic [2:0] dof;
    ro  = a[4:0] - ADDR_RW_LO[4:0];
    dof = a[2:0] - ADDR_DATAX0[2:0];
    unique case (1'b1)
      (a == ADDR_DEVID): return DEVID;
      is_rw(a):          return rw_q[ro];
      is_data(a):        return dat_q[dof];
      default:           return 8'h00;
    endcase
  endfunction

  always_comb begin
    state_d    = state_q;
    bit_d      = bit_q;
    rx_d       = rx_q;
    tx_d       = tx_q;
    tx_dat_d   = tx_dat_q;
    addr_d     = addr_q;
    rnw_d      = rnw_q;
    hit_d      = hit_q;
`ifdef GSENSOR_SPI_BURST_EN
    mb_d       = mb_q;
`endif
    rw_d       = rw_q;
    dat_d      = dat_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    rdy_d      = rdy_q;
    sdo_d      = sdo_q;
    stb_d      = 1'b0;
    wa_d       = wa_q;
    wd_d       = wd_q;
    byte_in    = {rx_q, sdi_s};
    cmd_addr   = byte_in[CMD_ADDR_MSB:CMD_ADDR_LSB];
    wr_off     = addr_q[4:0] - ADDR_RW_LO[4:0];
`ifdef GSENSOR_SPI_BURST_EN
    nxt_addr   = mb_q ? addr_q + 6'd1 : addr_q;
`else
    nxt_addr   = addr_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (csn_fall) begin
          state_d = ST_CMD;
          bit_d   = '0;
          rx_d    = '0;
          hit_d   = 1'b0;
        end
      end
      ST_CMD: begin
        if (sclk_re) begin
          rx_d  = byte_in[6:0];
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            state_d  = ST_DATA;
            rnw_d    = byte_in[CMD_RNW];
`ifdef GSENSOR_SPI_BURST_EN
            mb_d     = byte_in[CMD_MB];
`endif
            addr_d   = cmd_addr;
            tx_d     = reg_rd(cmd_addr);
            tx_dat_d = is_data(cmd_addr);
          end
        end
      end
      ST_DATA: begin
        if (sclk_fe && rnw_q) begin
          sdo_d = tx_q[7];
          tx_d  = {tx_q[6:0], 1'b1};
          // A data byte counts as returned once its
          // MSB goes out on the wire.
          if (bit_q == 3'd0)
            hit_d = hit_q | tx_dat_q;
        end
        if (sclk_re) begin
          rx_d  = byte_in[6:0];
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            addr_d   = nxt_addr;
            tx_d     = reg_rd(nxt_addr);
            tx_dat_d = is_data(nxt_addr);
            if (!rnw_q && is_rw(addr_q)) begin
              rw_d[wr_off] = byte_in;
              stb_d        = 1'b1;
              wa_d         = addr_q;
              wd_d         = byte_in;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (csn_rise) begin
      if (hit_q)
        rdy_d = 1'b0;
      state_d = ST_IDLE;
      bit_d   = '0;
      rx_d    = '0;
      hit_d   = 1'b0;
      sdo_d   = 1'b1;
    end

    // Placed after the clear so a copy on the same
    // cycle leaves DATA_READY set.
    if (pend_vld_q && csn_s && state_q == ST_IDLE) begin
      dat_d      = pend_q;
      rdy_d      = 1'b1;
      pend_vld_d = 1'b0;
    end
    if (iSAMPLE_VALID) begin
      pend_d     = iSAMPLE;
      pend_vld_d = 1'b1;
    end

    oe_d   = (state_d == ST_DATA) && rnw_d;
    int2_d = rdy_q & rw_q[IDX_INT_ENABLE][7]
                   & rw_q[IDX_INT_MAP][7];
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q    <= ST_IDLE;
      bit_q      <= '0;
      rx_q       <= '0;
      tx_q       <= '0;
      tx_dat_q   <= 1'b0;
      addr_q     <= '0;
      rnw_q      <= 1'b0;
      hit_q      <= 1'b0;
`ifdef GSENSOR_SPI_BURST_EN
      mb_q       <= 1'b0;
`endif
      rw_q       <= '0;
      dat_q      <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      rdy_q      <= 1'b0;
      sdo_q      <= 1'b1;
      oe_q       <= 1'b0;
      int2_q     <= 1'b0;
      stb_q      <= 1'b0;
      wa_q       <= '0;
      wd_q       <= '0;
    end else begin
      state_q    <= state_d;
      bit_q      <= bit_d;
      rx_q       <= rx_d;
      tx_q       <= tx_d;
      tx_dat_q   <= tx_dat_d;
      addr_q     <= addr_d;
      rnw_q      <= rnw_d;
      hit_q      <= hit_d;
`ifdef GSENSOR_SPI_BURST_EN
      mb_q       <= mb_d;
`endif
      rw_q       <= rw_d;
      dat_q      <= dat_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      rdy_q      <= rdy_d;
      sdo_q      <= sdo_d;
      oe_q       <= oe_d;
      int2_q     <= int2_d;
      stb_q      <= stb_d;
      wa_q       <= wa_d;
      wd_q       <= wd_d;
    end
  end

  assign oSPI_SDO    = sdo_q;
  assign oSPI_SDO_OE = oe_q;
  assign oINT2       = int2_q;
  assign oWR_STB     = stb_q;
  assign oWR_ADDR    = wa_q;
  assign oWR_DATA    = wd_q;

endmodule

// File: tb/tb_gsensor_spi_slave.sv
// Bench for gsensor_spi_slave: SPI master tasks, a
// register-map model and a write-pulse scoreboard.
`timescale 1ns/1ps
module tb_gsensor_spi_slave;

  localparam int HALF = 260;
`ifdef GSENSOR_SPI_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, csn, sclk, sdi;
  logic sdo, oe, int2, stb, svld;
  logic [47:0] sample;
  logic [5:0] wa;
  logic [7:0] wd;

  int n_chk = 0;
  int n_fail = 0;

  always #10 clk = ~clk;

  gsensor_spi_slave dut (
    .iCLK         (clk),
    .iRST         (rst),
    .iSPI_CSN     (csn),
    .iSPI_CLK     (sclk),
    .iSPI_SDI     (sdi),
    .oSPI_SDO     (sdo),
    .oSPI_SDO_OE  (oe),
    .iSAMPLE      (sample),
    .iSAMPLE_VALID(svld),
    .oINT2        (int2),
    .oWR_STB      (stb),
    .oWR_ADDR     (wa),
    .oWR_DATA     (wd)
  );

  logic [13:0] got_wr[$];
  logic [13:0] exp_wr[$];

  always @(negedge clk)
    if (stb) got_wr.push_back({wa, wd});

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---- reference model ----
  logic [7:0] m_rw [64];
  logic [47:0] m_data;
  bit m_rdy;

  task automatic m_reset();
    for (int i = 0; i < 64; i++) m_rw[i] = 8'h00;
    m_data = '0;
    m_rdy = 1'b0;
  endtask

  function automatic bit m_isrw(input logic [5:0] a);
    return a >= 6'h1D && a <= 6'h31;
  endfunction

  function automatic bit m_isdat(input logic [5:0] a);
    return a >= 6'h32 && a <= 6'h37;
  endfunction

  function automatic logic [7:0] m_read(
    input logic [5:0] a);
    if (a == 6'h00) return 8'hE5;
    if (m_isrw(a)) return m_rw[a];
    if (m_isdat(a))
      return m_data[(int'(a) - 'h32) * 8 +: 8];
    return 8'h00;
  endfunction

  function automatic logic [5:0] m_next(
    input logic [5:0] a, input bit mb);
    return (mb && BURST) ? a + 6'd1 : a;
  endfunction

  function automatic bit m_int();
    return m_rdy && m_rw[6'h2E][7] && m_rw[6'h2F][7];
  endfunction

  // ---- SPI master (mode 3) ----
  logic [7:0] wbuf [8];
  logic [7:0] rbuf [8];
  logic [7:0] ebuf [8];
  int cmd_oe, data_oe;

  task automatic spi_byte(input logic [7:0] tx,
                          input int nb,
                          output logic [7:0] rx,
                          output int oe_n);
    rx = 8'h00;
    oe_n = 0;
    for (int i = 0; i < nb; i++) begin
      sclk = 1'b0;
      sdi = tx[7-i];
      #HALF;
      rx[7-i] = sdo;
      if (oe) oe_n++;
      sclk = 1'b1;
      #HALF;
    end
  endtask

  task automatic spi_begin();
    csn = 1'b0;
    #HALF;
  endtask

  task automatic spi_end();
    #HALF;
    csn = 1'b1;
    #(HALF * 2);
  endtask

  task automatic xfer(input logic [7:0] cmd,
                      input int n, input int mid);
    logic [7:0] d;
    int k;
    spi_begin();
    spi_byte(cmd, 8, d, k);
    cmd_oe = k;
    data_oe = 0;
    for (int i = 0; i < n; i++) begin
      if (i == mid) begin
        svld = 1'b1;
        #20;
        svld = 1'b0;
      end
      spi_byte(wbuf[i], 8, rbuf[i], k);
      data_oe += k;
    end
    spi_end();
  endtask

  task automatic check_wr(input string tag);
    chk({tag, "_wr_n"}, got_wr.size(), exp_wr.size());
    while (got_wr.size() > 0 && exp_wr.size() > 0)
      chk({tag, "_wr"}, got_wr.pop_front(),
          exp_wr.pop_front());
    got_wr.delete();
    exp_wr.delete();
  endtask

  task automatic xfer_chk(input string tag,
                          input logic [7:0] cmd,
                          input int n, input int mid);
    logic [5:0] a;
    bit rd, mb, hit;
    rd = cmd[7];
    mb = cmd[6];
    a = cmd[5:0];
    hit = 1'b0;
    for (int i = 0; i < n; i++) begin
      ebuf[i] = m_read(a);
      if (rd && m_isdat(a)) hit = 1'b1;
      if (!rd && m_isrw(a)) begin
        m_rw[a] = wbuf[i];
        exp_wr.push_back({a, wbuf[i]});
      end
      a = m_next(a, mb);
    end
    xfer(cmd, n, mid);
    if (rd)
      for (int i = 0; i < n; i++)
        chk($sformatf("%s_rd%0d", tag, i),
            rbuf[i], ebuf[i]);
    chk({tag, "_oe"}, {cmd_oe, data_oe},
        {32'd0, rd ? 32'(8 * n) : 32'd0});
    chk({tag, "_oe_end"}, oe, 1'b0);
    if (rd && hit) m_rdy = 1'b0;
    if (mid >= 0) begin
      m_data = sample;
      m_rdy = 1'b1;
    end
    check_wr(tag);
    chk({tag, "_int2"}, int2, m_int());
  endtask

  task automatic strobe(input logic [47:0] s);
    sample = s;
    svld = 1'b1;
    #20;
    svld = 1'b0;
    #100;
    m_data = s;
    m_rdy = 1'b1;
  endtask

  logic [7:0] exp34 [6];
  logic [7:0] d8;
  logic [63:0] r64;
  int k;

  initial begin
    rst = 1'b1;
    csn = 1'b1;
    sclk = 1'b1;
    sdi = 1'b1;
    sample = '0;
    svld = 1'b0;
    m_reset();
    @(posedge clk);
    #5;
    #80;
    chk("rst_out", {sdo, oe, int2, stb, wa, wd},
        {1'b1, 1'b0, 1'b0, 1'b0, 6'h00, 8'h00});
    rst = 1'b0;
    #20;
    chk("rst_out1", {sdo, oe, int2, stb, wa, wd},
        {1'b1, 1'b0, 1'b0, 1'b0, 6'h00, 8'h00});
    #200;

    // DEVID read
    xfer_chk("devid", 8'h80, 1, -1);
    chk("devid_val", rbuf[0], 8'hE5);
    chk("devid_oe8", data_oe, 8);

    // write then readback
    wbuf[0] = 8'h08;
    xfer_chk("wr2d", 8'h2D, 1, -1);
    chk("wr2d_hold", {wa, wd}, {6'h2D, 8'h08});
    xfer_chk("rd2d", 8'hAD, 1, -1);
    chk("rd2d_val", rbuf[0], 8'h08);

    // burst read of a known sample
    strobe({16'h0003, 16'hFFFE, 16'h0102});
    xfer_chk("burst", 8'hF2, 6, -1);
    if (BURST) begin
      exp34[0] = 8'h02; exp34[1] = 8'h01;
      exp34[2] = 8'hFE; exp34[3] = 8'hFF;
      exp34[4] = 8'h03; exp34[5] = 8'h00;
    end else begin
      for (int i = 0; i < 6; i++) exp34[i] = 8'h02;
    end
    for (int i = 0; i < 6; i++)
      chk($sformatf("burst_const%0d", i),
          rbuf[i], exp34[i]);

    // interrupt set and clear
    wbuf[0] = 8'h80;
    xfer_chk("wr_ie", 8'h2E, 1, -1);
    xfer_chk("wr_im", 8'h2F, 1, -1);
    strobe(48'h1234_5678_9ABC);
    chk("int2_set", int2, 1'b1);
    xfer_chk("rd32", 8'hB2, 1, -1);
    chk("int2_clr", int2, 1'b0);

    // sample arriving mid-burst stays deferred
    strobe(48'hA1A2_B1B2_C1C2);
    sample = 48'h1111_2222_3333;
    xfer_chk("mid", 8'hF2, 6, 2);
    chk("mid_old0", rbuf[0], 8'hC2);
    chk("mid_int2", int2, 1'b1);
    xfer_chk("mid_new", 8'hF2, 6, -1);
    chk("mid_new0", rbuf[0], 8'h33);

    // partial write byte is dropped
    wbuf[0] = 8'h3C;
    xfer_chk("wr1e", 8'h1E, 1, -1);
    spi_begin();
    spi_byte(8'h1E, 8, d8, k);
    spi_byte(8'hC3, 5, d8, k);
    spi_end();
    check_wr("part");
    xfer_chk("rd1e", 8'h9E, 1, -1);
    chk("part_keep", rbuf[0], 8'h3C);

    // reset in the middle of a read
    wbuf[0] = 8'h5A;
    xfer_chk("wr1d", 8'h1D, 1, -1);
    spi_begin();
    spi_byte(8'h80, 8, d8, k);
    spi_byte(8'hFF, 3, d8, k);
    chk("pre_rst_oe", oe, 1'b1);
    rst = 1'b1;
    #20;
    chk("mid_rst_out", {oe, sdo}, {1'b0, 1'b1});
    #40;
    rst = 1'b0;
    #100;
    spi_byte(8'h1D, 8, d8, k);
    spi_byte(8'hA5, 8, d8, k);
    chk("busy_oe", oe, 1'b0);
    spi_end();
    m_reset();
    check_wr("busy");
    xfer_chk("rd1d", 8'h9D, 1, -1);
    chk("rst_clr1d", rbuf[0], 8'h00);

    // randomized traffic
    for (int t = 0; t < 30; t++) begin
      if ($urandom_range(0, 2) == 0) begin
        r64 = {$urandom, $urandom};
        strobe(r64[47:0]);
      end
      k = $urandom_range(1, 3);
      for (int i = 0; i < k; i++)
        wbuf[i] = 8'($urandom);
      xfer_chk($sformatf("rnd%0d", t),
               8'($urandom), k, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             n_chk, n_fail);
    $finish;
  end

endmodule
